// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Purpose  : Issue stage for the 64-bit ALU. It buffers operations in a FIFO,
//            holds multiply operands for the multiplier latency, and returns
//            tagged results. Optional macro ALU_SEQ_ERR_EN adds the out_err
//            flag for unsupported opcodes.
// Revision : 1.0  initial release
// ============================================================================
module alu_sequencer #(
    parameter int DEPTH       = 4,
    parameter int MUL_LATENCY = 2,
    parameter int TAG_W       = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_op,
    input  logic [63:0]      in_a,
    input  logic [63:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [5:0]       alu_op,
    output logic [63:0]      alu_a,
    output logic [63:0]      alu_b,
    input  logic [63:0]      alu_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic [TAG_W-1:0] out_tag
`ifdef ALU_SEQ_ERR_EN
    ,
    output logic             out_err
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int LAT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

    localparam logic [5:0]       OP_MUL   = 6'h14;
    localparam logic [5:0]       OP_IDLE  = 6'h3F;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    // The ISSUE cycle that spots the multiply already counts as one latency cycle.
    localparam logic [LAT_W-1:0] MUL_LOAD = LAT_W'(MUL_LATENCY - 1);

    typedef enum logic [0:0] {
        ST_ISSUE    = 1'b0,
        ST_MUL_WAIT = 1'b1
    } state_t;

    logic [5:0]       mem_op  [DEPTH];
    logic [63:0]      mem_a   [DEPTH];
    logic [63:0]      mem_b   [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [LAT_W-1:0] cnt;
    logic [LAT_W-1:0] cnt_nx;
    state_t           state;
    state_t           state_nx;

    logic head_valid;
    logic out_free;
    logic push;
    logic pop;

    assign head_valid = (count != '0);
    assign in_ready   = (count != CNT_FULL);
    assign push       = in_valid & in_ready;
    assign out_free   = ~out_valid | out_ready;

    assign alu_op = head_valid ? mem_op[rd_ptr] : OP_IDLE;
    assign alu_a  = head_valid ? mem_a[rd_ptr]  : 64'd0;
    assign alu_b  = head_valid ? mem_b[rd_ptr]  : 64'd0;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pop      = 1'b0;
        case (state)
            ST_ISSUE: begin
                if (head_valid) begin
                    if (alu_op == OP_MUL) begin
                        cnt_nx   = MUL_LOAD;
                        state_nx = ST_MUL_WAIT;
                    end else if (out_free) begin
                        pop = 1'b1;
                    end
                end
            end
            ST_MUL_WAIT: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - LAT_W'(1);
                end else if (out_free) begin
                    pop      = 1'b1;
                    state_nx = ST_ISSUE;
                end
            end
            default: begin
                state_nx = ST_ISSUE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_ISSUE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Storage needs no reset: nothing is read unless count says it was written.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_op[wr_ptr]  <= in_op;
            mem_a[wr_ptr]   <= in_a;
            mem_b[wr_ptr]   <= in_b;
            mem_tag[wr_ptr] <= in_tag;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= 64'd0;
            out_tag   <= '0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_data  <= alu_out;
            out_tag   <= mem_tag[rd_ptr];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ALU_SEQ_ERR_EN
    logic head_err;

    // Supported opcodes are 00 and the contiguous range 07..14.
    assign head_err = ~((alu_op == 6'h00) || ((alu_op >= 6'h07) && (alu_op <= 6'h14)));

    always_ff @(posedge clock) begin
        if (reset) begin
            out_err <= 1'b0;
        end else if (pop) begin
            out_err <= head_err;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sequencer
// Purpose  : Self-checking bench for alu_sequencer with a behavioural ALU and
//            an in-order result scoreboard. Honours ALU_SEQ_ERR_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_sequencer;

    localparam int DEPTH       = 4;
    localparam int MUL_LATENCY = 2;
    localparam int TAG_W       = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       in_op;
    logic [63:0]      in_a;
    logic [63:0]      in_b;
    logic [TAG_W-1:0] in_tag;
    logic [5:0]       alu_op;
    logic [63:0]      alu_a;
    logic [63:0]      alu_b;
    logic [63:0]      alu_out;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_data;
    logic [TAG_W-1:0] out_tag;
`ifdef ALU_SEQ_ERR_EN
    logic             out_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [63:0]      data;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    exp_t sb[$];

    alu_sequencer #(
        .DEPTH       (DEPTH),
        .MUL_LATENCY (MUL_LATENCY),
        .TAG_W       (TAG_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_out   (alu_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
`ifdef ALU_SEQ_ERR_EN
        ,
        .out_err   (out_err)
`endif
    );

    always #5 clock = ~clock;

    // Result an ideal ALU produces for an operation, independent of timing.
    function automatic logic [63:0] ref_result(input logic [5:0] op, input logic [63:0] a,
                                               input logic [63:0] b);
        case (op)
            6'h00:   return a + b;
            6'h08:   return a & b;
            6'h09:   return a | b;
            6'h0A:   return a ^ b;
            6'h14:   return a * b;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic ref_err(input logic [5:0] op);
        return !((op == 6'h00) || ((op >= 6'h07) && (op <= 6'h14)));
    endfunction

    // ALU model: single-cycle ops combinational, multiply through a pipeline.
    logic [63:0] mul_pipe [MUL_LATENCY];

    always_ff @(posedge clock) begin
        mul_pipe[0] <= alu_a * alu_b;
        for (int i = 1; i < MUL_LATENCY; i++) begin
            mul_pipe[i] <= mul_pipe[i-1];
        end
    end

    always_comb begin
        alu_out = 64'd0;
        if (alu_op == 6'h14) begin
            alu_out = mul_pipe[MUL_LATENCY-1];
        end else begin
            alu_out = ref_result(alu_op, alu_a, alu_b);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted op must come back once, in acceptance order.
    always @(negedge clock) begin
        if (reset) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_result", 64'(out_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_data", out_data, e.data);
                    check("sb_tag", 64'(out_tag), 64'(e.tag));
`ifdef ALU_SEQ_ERR_EN
                    check("sb_err", 64'(out_err), 64'(e.err));
`endif
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back('{data: ref_result(in_op, in_a, in_b), tag: in_tag,
                               err: ref_err(in_op)});
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [TAG_W-1:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 50 && !in_ready; k++) begin
            step();
        end
        if (!in_ready) begin
            check("in_ready_timeout", 64'(in_ready), 64'd1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    logic [5:0] op_pool [7] = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h14, 6'h3A, 6'h3F};

    initial begin
        reset     = 1'b1;
        out_ready = 1'b0;
        drive(6'h00, 64'd1, 64'd1, '0);

        // Reset held two cycles with an offered op
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_in_ready", 64'(in_ready), 64'd1);
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_alu_op", 64'(alu_op), 64'h3F);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        step();
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);
        check("post_rst_alu_op", 64'(alu_op), 64'h3F);
        check("post_rst_alu_a", alu_a, 64'd0);
        check("post_rst_out_data", out_data, 64'd0);
        check("post_rst_out_tag", 64'(out_tag), 64'd0);

        // Single add: result two cycles after the push edge
        out_ready = 1'b1;
        drive(6'h00, 64'd5, 64'd7, 4'd3);
        step();
        in_valid = 1'b0;
        check("add_head_op", 64'(alu_op), 64'h00);
        check("add_not_yet_valid", 64'(out_valid), 64'd0);
        step();
        check("add_valid", 64'(out_valid), 64'd1);
        check("add_data", out_data, 64'd12);
        check("add_tag", 64'(out_tag), 64'd3);
        step();
        check("add_consumed", 64'(out_valid), 64'd0);

        // Multiply: operands held MUL_LATENCY+1 cycles, result at push+2+MUL_LATENCY
        drive(6'h14, 64'd6, 64'd7, 4'd5);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < MUL_LATENCY + 1; i++) begin
            check("mul_hold_a", alu_a, 64'd6);
            check("mul_hold_b", alu_b, 64'd7);
            check("mul_not_yet_valid", 64'(out_valid), 64'd0);
            step();
        end
        check("mul_valid", 64'(out_valid), 64'd1);
        check("mul_data", out_data, 64'd42);
        check("mul_tag", 64'(out_tag), 64'd5);
        check("mul_fifo_empty", 64'(alu_op), 64'h3F);
        step();
        check("mul_consumed", 64'(out_valid), 64'd0);

        // Backpressure: five pushes fill the output register plus all FIFO entries
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(6'h00, 64'(i), 64'd100, TAG_W'(i));
            wait_ready();
            step();
        end
        in_valid = 1'b0;
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_out_tag", 64'(out_tag), 64'd0);
        step();
        check("full_in_ready_held", 64'(in_ready), 64'd0);
        check("full_out_tag_held", 64'(out_tag), 64'd0);
        out_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            step();
            check("drain_valid", 64'(out_valid), 64'd1);
            check("drain_tag", 64'(out_tag), 64'(i));
            check("drain_data", out_data, 64'(i + 100));
            if (i == 1) begin
                check("drain_in_ready", 64'(in_ready), 64'd1);
            end
        end
        step();
        check("drain_done", 64'(out_valid), 64'd0);

        // Reset while a multiply waits behind a stalled output with a full queue
        out_ready = 1'b0;
        drive(6'h00, 64'd1, 64'd2, 4'hA);
        step();
        drive(6'h14, 64'd3, 64'd4, 4'd1);
        step();
        for (int i = 2; i < 5; i++) begin
            drive(6'h09, 64'(i), 64'd8, TAG_W'(i));
            step();
        end
        in_valid = 1'b0;
        check("mw_full", 64'(in_ready), 64'd0);
        check("mw_head_mul", 64'(alu_op), 64'h14);
        step();
        check("mw_head_held", alu_a, 64'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mw_rst_out_valid", 64'(out_valid), 64'd0);
        check("mw_rst_in_ready", 64'(in_ready), 64'd1);
        check("mw_rst_alu_op", 64'(alu_op), 64'h3F);
        check("mw_rst_out_data", out_data, 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("mw_quiet_valid", 64'(out_valid), 64'd0);
            check("mw_quiet_alu_op", 64'(alu_op), 64'h3F);
        end
        drive(6'h00, 64'h11, 64'h22, 4'd9);
        step();
        in_valid = 1'b0;
        step();
        check("mw_after_valid", 64'(out_valid), 64'd1);
        check("mw_after_data", out_data, 64'h33);
        step();

`ifdef ALU_SEQ_ERR_EN
        drive(6'h3A, 64'd5, 64'd5, 4'd2);
        step();
        in_valid = 1'b0;
        step();
        check("err_bad_data", out_data, 64'd0);
        check("err_bad_flag", 64'(out_err), 64'd1);
        drive(6'h0A, 64'hF0, 64'hFF, 4'd4);
        step();
        in_valid = 1'b0;
        step();
        check("err_ok_data", out_data, 64'h0F);
        check("err_ok_flag", 64'(out_err), 64'd0);
        step();
`endif

        // Random traffic against the scoreboard
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_op     = op_pool[$urandom_range(0, 6)];
            in_a      = {$urandom, $urandom};
            in_b      = {$urandom, $urandom};
            in_tag    = TAG_W'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 200 && (sb.size() != 0 || out_valid); k++) begin
            step();
        end
        check("final_sb_empty", 64'(sb.size()), 64'd0);
        check("final_out_valid", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
